// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator request scheduler.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 8;
    localparam int FLOOR_W_DEF    = 3;

    // Direction encodings presented to the car.
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    // Scheduler control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SELECT = 2'b01,
        ST_MOVE   = 2'b10,
        ST_DOOR   = 2'b11
    } sched_state_t;

    // SCAN sweep direction; the encoding is also the sweep port bit of the picker.
    typedef enum logic {
        SWEEP_UP   = 1'b0,
        SWEEP_DOWN = 1'b1
    } sweep_t;

endpackage

// File: rtl/elevator_scan_pick.sv
// Combinational SCAN target picker. Two masked priority encoders find the
// nearest pending floor strictly above and strictly below the car; the sweep
// direction chooses between them and reports when the sweep has to reverse.
module elevator_scan_pick
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  sweep,        // 0 = up, 1 = down
    output logic [FLOOR_W-1:0]    target,
    output logic                  found,
    output logic                  flip_sweep,
    output logic                  above_found,  // some pending floor above the car
    output logic [FLOOR_W-1:0]    above_floor,  // lowest pending floor above the car
    output logic                  below_found,  // some pending floor below the car
    output logic [FLOOR_W-1:0]    below_floor   // highest pending floor below the car
);

    logic [NUM_FLOORS-1:0] above_mask;
    logic [NUM_FLOORS-1:0] below_mask;
    logic                  cur_hit;

    // Split the pending mask around the car; an out-of-range floor matches nothing.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        above_mask = '0;
        below_mask = '0;
        cur_hit    = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_mask[i] = pending[i] && (i > int'(cur_floor));
            below_mask[i] = pending[i] && (i < int'(cur_floor));
            if (pending[i] && (i == int'(cur_floor))) begin
                cur_hit = 1'b1;
            end
        end
    end

    // Lowest set bit of the above mask: scan downward so the last hit wins.
    always_comb begin
        above_found = 1'b0;
        above_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (above_mask[i]) begin
                above_found = 1'b1;
                above_floor = FLOOR_W'(i);
            end
        end
    end

    // Highest set bit of the below mask: scan upward so the last hit wins.
    always_comb begin
        below_found = 1'b0;
        below_floor = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (below_mask[i]) begin
                below_found = 1'b1;
                below_floor = FLOOR_W'(i);
            end
        end
    end

    // SCAN choice: serve the current floor first, then continue the sweep, reversing only when it is exhausted.
    always_comb begin
        target     = '0;
        found      = 1'b0;
        flip_sweep = 1'b0;
        if (cur_hit) begin
            target = cur_floor;
            found  = 1'b1;
        end else if (sweep_t'(sweep) == SWEEP_UP) begin
            if (above_found) begin
                target = above_floor;
                found  = 1'b1;
            end else if (below_found) begin
                target     = below_floor;
                found      = 1'b1;
                flip_sweep = 1'b1;
            end
        end else begin
            if (below_found) begin
                target = below_floor;
                found  = 1'b1;
            end else if (above_found) begin
                target     = above_floor;
                found      = 1'b1;
                flip_sweep = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN request scheduler in front of the elevator car. Collects floor calls
// into a pending mask, dispatches one target at a time, retargets to closer
// calls on the way, and times the door dwell (held open while over weight).
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = NUM_FLOORS_DEF,
    parameter int FLOOR_W     = FLOOR_W_DEF,
    parameter int DOOR_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  complete,
    input  logic                  over_weight,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic                  req_valid,
    output logic [1:0]            direction,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    // The dwell counter only ever holds DOOR_CYCLES-1 down to 0.
    localparam int               CNT_W     = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

    sched_state_t          state_q,     state_d;
    sweep_t                sweep_q,     sweep_d;
    logic [NUM_FLOORS-1:0] pending_q,   pending_d;
    logic [FLOOR_W-1:0]    target_q,    target_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  req_valid_q, req_valid_d;
    logic [1:0]            direction_q, direction_d;
    logic                  door_open_q, door_open_d;

    logic                  enter_door;
    logic [NUM_FLOORS-1:0] cur_onehot;

    logic                  pick_found;
    logic                  pick_flip;
    logic [FLOOR_W-1:0]    pick_target;
    logic                  above_found;
    logic [FLOOR_W-1:0]    above_floor;
    logic                  below_found;
    logic [FLOOR_W-1:0]    below_floor;

    // One picker serves both the SELECT decision and the MOVE retarget check.
    elevator_scan_pick #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_pick (
        .pending     (pending_q),
        .cur_floor   (cur_floor),
        .sweep       (sweep_q),
        .target      (pick_target),
        .found       (pick_found),
        .flip_sweep  (pick_flip),
        .above_found (above_found),
        .above_floor (above_floor),
        .below_found (below_found),
        .below_floor (below_floor)
    );

    // One-hot of the car position; stays zero when the car reports a floor that does not exist.
    always_comb begin
        cur_onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cur_onehot[i] = (i == int'(cur_floor));
        end
    end

    // Next-state logic: state transitions, target selection/retarget, sweep and dwell counter.
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        enter_door = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    state_d = ST_SELECT;
                end
            end

            ST_SELECT: begin
                if (pick_found) begin
                    target_d = pick_target;
                    if (pick_flip) begin
                        sweep_d = (sweep_q == SWEEP_UP) ? SWEEP_DOWN : SWEEP_UP;
                    end
                    if (pick_target == cur_floor) begin
                        state_d    = ST_DOOR;
                        enter_door = 1'b1;
                    end else begin
                        state_d = ST_MOVE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_MOVE: begin
                if (complete && (cur_floor == target_q)) begin
                    state_d    = ST_DOOR;
                    enter_door = 1'b1;
                end else if (target_q > cur_floor) begin
                    // Travelling up: stop at a nearer call that lies strictly on the way.
                    if (above_found && (above_floor < target_q)) begin
                        target_d = above_floor;
                    end
                end else if (target_q < cur_floor) begin
                    // Travelling down: same rule mirrored.
                    if (below_found && (below_floor > target_q)) begin
                        target_d = below_floor;
                    end
                end
            end

            ST_DOOR: begin
                // The dwell keeps counting while overloaded; only the exit waits for the load to drop.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!over_weight) begin
                    state_d = (pending_q != '0) ? ST_SELECT : ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (enter_door) begin
            cnt_d = DOOR_LOAD;
        end
    end

    // Pending mask and registered outputs, all derived from the next state so no input reaches an output directly.
    always_comb begin
        // A floor pressed on the very edge its door opens is treated as already served.
        pending_d   = (pending_q | call_req) & ~(enter_door ? cur_onehot : '0);
        req_valid_d = (state_d == ST_MOVE);
        door_open_d = (state_d == ST_DOOR);
        direction_d = DIR_IDLE;
        if (state_d == ST_MOVE) begin
            if (target_d > cur_floor) begin
                direction_d = DIR_UP;
            end else if (target_d < cur_floor) begin
                direction_d = DIR_DOWN;
            end else begin
                // Car is at the target but has not reported completion yet: keep the last heading.
                direction_d = direction_q;
            end
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sweep_q     <= SWEEP_UP;
            pending_q   <= '0;
            target_q    <= '0;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            direction_q <= DIR_IDLE;
            door_open_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            pending_q   <= pending_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            direction_q <= direction_d;
            door_open_q <= door_open_d;
        end
    end

    assign req_floor = target_q;
    assign req_valid = req_valid_q;
    assign direction = direction_q;
    assign door_open = door_open_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: dispatch vectors, hand-written
// corner sequences, and randomized call batches checked against a SCAN model.
module tb_elevator_scheduler;
    import elevator_pkg::*;

    localparam int NF = 8;
    localparam int FW = 3;
    localparam int DC = 4;

    logic          clk;
    logic          rst_n;
    logic [NF-1:0] call_req;
    logic [FW-1:0] cur_floor;
    logic          complete;
    logic          over_weight;
    logic [FW-1:0] req_floor;
    logic          req_valid;
    logic [1:0]    direction;
    logic          door_open;
    logic [NF-1:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: outstanding floors and sweep heading.
    logic [NF-1:0] model_pend;
    logic          model_up;

    elevator_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .call_req    (call_req),
        .cur_floor   (cur_floor),
        .complete    (complete),
        .over_weight (over_weight),
        .req_floor   (req_floor),
        .req_valid   (req_valid),
        .direction   (direction),
        .door_open   (door_open),
        .pending     (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] call;
        logic [2:0] cur;
        logic       vld;
        logic [2:0] flr;
        logic [1:0] dir;
        logic       door;
        logic [7:0] pend;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        call_req    = '0;
        complete    = 1'b0;
        over_weight = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_call(input logic [7:0] mask);
        call_req = mask;
        tick();
        call_req = '0;
    endtask

    // SCAN rule from the model's own pending set: current floor first, then
    // nearest floor ahead in the sweep, otherwise nearest behind and reverse.
    task automatic model_next(output int tgt);
        int above[$];
        int below[$];
        tgt = 0;
        if (model_pend[cur_floor]) begin
            tgt = int'(cur_floor);
            return;
        end
        for (int f = 0; f < NF; f++) begin
            if (model_pend[f]) begin
                if (f > int'(cur_floor)) above.push_back(f);
                else                     below.push_back(f);
            end
        end
        above.sort();
        below.sort();
        if (model_up) begin
            if (above.size() > 0) tgt = above[0];
            else begin tgt = below[below.size() - 1]; model_up = 1'b0; end
        end else begin
            if (below.size() > 0) tgt = below[below.size() - 1];
            else begin tgt = above[0]; model_up = 1'b1; end
        end
    endtask

    // Car emulation for one stop: drive to the dispatched floor, report arrival,
    // hold over_weight for the first ow_cycles door cycles, and measure the dwell.
    // The door closes at the first cycle with at least DC cycles elapsed and no overload.
    task automatic serve(input int exp_floor, input int ow_cycles, input logic [7:0] exp_pend);
        int t;
        int steps;
        int len;
        int exp_len;
        int exp_dir;
        t = 0;
        while (!req_valid && !door_open && t < 20) begin
            tick();
            t++;
        end
        if (req_valid) begin
            check("dispatch_floor", int'(req_floor), exp_floor);
            exp_dir = (exp_floor > int'(cur_floor)) ? int'(DIR_UP) : int'(DIR_DOWN);
            check("dispatch_dir", int'(direction), exp_dir);
            steps = 0;
            while (cur_floor != req_floor && steps < 16) begin
                cur_floor = (cur_floor < req_floor) ? cur_floor + 3'd1 : cur_floor - 3'd1;
                tick();
                tick();
                steps++;
            end
            complete = 1'b1;
            tick();
            complete = 1'b0;
        end else if (!door_open) begin
            fail_now("serve_wait");
            return;
        end
        check("door_open", int'(door_open), 1);
        check("door_floor", int'(cur_floor), exp_floor);
        check("door_pending", int'(pending), int'(exp_pend));
        check("door_no_valid", int'(req_valid), 0);
        len = 0;
        while (door_open && len < 40) begin
            over_weight = (len < ow_cycles);
            len++;
            tick();
        end
        over_weight = 1'b0;
        exp_len = DC;
        for (int c = 1; c <= 40; c++) begin
            if (c >= DC && c > ow_cycles) begin
                exp_len = c;
                break;
            end
        end
        check("door_len", len, exp_len);
    endtask

    initial begin
        int   len;
        logic seen_valid;

        rst_n       = 1'b0;
        call_req    = '0;
        cur_floor   = '0;
        complete    = 1'b0;
        over_weight = 1'b0;
        model_pend  = '0;
        model_up    = 1'b1;

        //                call    cur   vld   flr   dir       door  pend
        vecs[0] = '{8'h20, 3'd1, 1'b1, 3'd5, DIR_UP,   1'b0, 8'h20};
        vecs[1] = '{8'h04, 3'd6, 1'b1, 3'd2, DIR_DOWN, 1'b0, 8'h04};
        vecs[2] = '{8'h08, 3'd3, 1'b0, 3'd3, DIR_IDLE, 1'b1, 8'h00};
        vecs[3] = '{8'h80, 3'd0, 1'b1, 3'd7, DIR_UP,   1'b0, 8'h80};
        vecs[4] = '{8'h03, 3'd4, 1'b1, 3'd1, DIR_DOWN, 1'b0, 8'h03};
        vecs[5] = '{8'h41, 3'd4, 1'b1, 3'd6, DIR_UP,   1'b0, 8'h41};
        vecs[6] = '{8'h81, 3'd7, 1'b0, 3'd7, DIR_IDLE, 1'b1, 8'h01};
        vecs[7] = '{8'h5A, 3'd4, 1'b0, 3'd4, DIR_IDLE, 1'b1, 8'h4A};
        vecs[8] = '{8'h01, 3'd0, 1'b0, 3'd0, DIR_IDLE, 1'b1, 8'h00};

        // Reset state.
        do_reset();
        check("rst_req_valid", int'(req_valid), 0);
        check("rst_req_floor", int'(req_floor), 0);
        check("rst_direction", int'(direction), int'(DIR_IDLE));
        check("rst_door_open", int'(door_open), 0);
        check("rst_pending",   int'(pending), 0);

        // Single-call dispatch vectors: outputs three edges after the call.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            cur_floor = vecs[i].cur;
            pulse_call(vecs[i].call);
            check("vec_pend_set", int'(pending), int'(vecs[i].call));
            tick();
            tick();
            check("vec_req_valid", int'(req_valid), int'(vecs[i].vld));
            check("vec_req_floor", int'(req_floor), int'(vecs[i].flr));
            check("vec_direction", int'(direction), int'(vecs[i].dir));
            check("vec_door_open", int'(door_open), int'(vecs[i].door));
            check("vec_pending",   int'(pending), int'(vecs[i].pend));
        end

        // Full trip 1 -> 5, stray complete ignored, 4-cycle dwell, back to idle.
        do_reset();
        cur_floor = 3'd1;
        pulse_call(8'h20);
        tick();
        tick();
        check("trip_valid", int'(req_valid), 1);
        check("trip_floor", int'(req_floor), 5);
        check("trip_dir",   int'(direction), int'(DIR_UP));
        cur_floor = 3'd3;
        complete  = 1'b1;
        tick();
        complete = 1'b0;
        check("stray_complete_door", int'(door_open), 0);
        check("stray_complete_valid", int'(req_valid), 1);
        cur_floor = 3'd5;
        tick();
        complete = 1'b1;
        tick();
        complete = 1'b0;
        check("trip_door",    int'(door_open), 1);
        check("trip_pending", int'(pending), 0);
        check("trip_dir_door", int'(direction), int'(DIR_IDLE));
        len = 0;
        while (door_open && len < 20) begin
            len++;
            tick();
        end
        check("trip_dwell", len, DC);
        tick();
        tick();
        check("trip_idle_valid", int'(req_valid), 0);
        check("trip_idle_door",  int'(door_open), 0);

        // SCAN order from floor 1 with calls {0,3,6}: 3, 6, then reverse to 0.
        do_reset();
        cur_floor = 3'd1;
        pulse_call(8'h49);
        serve(3, 0, 8'h41);
        serve(6, 0, 8'h01);
        serve(0, 0, 8'h00);

        // Retarget: heading 2 -> 7, call below (2) is ignored, call ahead (4) wins.
        do_reset();
        cur_floor = 3'd2;
        pulse_call(8'h80);
        tick();
        tick();
        check("rt_floor_7", int'(req_floor), 7);
        cur_floor = 3'd3;
        tick();
        pulse_call(8'h04);
        tick();
        tick();
        check("rt_below_ignored", int'(req_floor), 7);
        pulse_call(8'h10);
        check("rt_not_yet", int'(req_floor), 7);
        tick();
        check("rt_floor_4", int'(req_floor), 4);
        check("rt_pending", int'(pending), 8'h94);
        check("rt_dir", int'(direction), int'(DIR_UP));
        cur_floor = 3'd4;
        complete  = 1'b1;
        tick();
        complete = 1'b0;
        check("rt_door", int'(door_open), 1);
        check("rt_pending_after", int'(pending), 8'h84);

        // Overload at floor 5: 10 overloaded cycles keep the door open exactly that long.
        do_reset();
        cur_floor = 3'd3;
        pulse_call(8'h22);
        tick();
        cur_floor = 3'd4;
        tick();
        cur_floor = 3'd5;
        tick();
        complete    = 1'b1;
        over_weight = 1'b1;
        tick();
        complete = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            check("ow_door_held", int'(door_open), 1);
            check("ow_no_valid", int'(req_valid), 0);
            tick();
        end
        over_weight = 1'b0;
        check("ow_door_last", int'(door_open), 1);
        tick();
        check("ow_door_closed", int'(door_open), 0);
        check("ow_still_no_valid", int'(req_valid), 0);
        tick();
        check("ow_next_valid", int'(req_valid), 1);
        check("ow_next_floor", int'(req_floor), 1);
        check("ow_next_dir", int'(direction), int'(DIR_DOWN));

        // Call at the current floor: SELECT then DOOR, no dispatch; re-press on entry edge dropped.
        do_reset();
        cur_floor  = 3'd3;
        seen_valid = 1'b0;
        pulse_call(8'h08);
        seen_valid |= req_valid;
        tick();
        seen_valid |= req_valid;
        pulse_call(8'h08);
        seen_valid |= req_valid;
        check("hit_door", int'(door_open), 1);
        check("hit_press_dropped", int'(pending), 0);
        for (int c = 0; c < DC + 4; c++) begin
            tick();
            seen_valid |= req_valid;
        end
        check("hit_no_valid", int'(seen_valid), 0);
        check("hit_idle_door", int'(door_open), 0);
        check("hit_idle_pending", int'(pending), 0);

        // Asynchronous reset in the middle of a move with every floor pending.
        do_reset();
        cur_floor = 3'd0;
        pulse_call(8'hFE);
        tick();
        tick();
        check("ar_moving", int'(req_valid), 1);
        pulse_call(8'hFF);
        check("ar_pending_full", int'(pending), 8'hFF);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_req_valid", int'(req_valid), 0);
        check("ar_req_floor", int'(req_floor), 0);
        check("ar_direction", int'(direction), int'(DIR_IDLE));
        check("ar_door_open", int'(door_open), 0);
        check("ar_pending",   int'(pending), 0);
        tick();
        rst_n = 1'b1;

        // Randomized call batches served by the emulated car against the SCAN model.
        do_reset();
        model_up  = 1'b1;
        cur_floor = 3'($urandom_range(0, 7));
        for (int r = 0; r < 25; r++) begin
            logic [7:0] mask;
            int         tgt;
            int         guard;
            mask = 8'($urandom_range(1, 255));
            pulse_call(mask);
            check("rnd_pend_set", int'(pending), int'(mask));
            model_pend = mask;
            guard = 0;
            while (model_pend != '0 && guard < 10) begin
                model_next(tgt);
                model_pend[tgt] = 1'b0;
                serve(tgt, int'($urandom_range(0, 6)), model_pend);
                guard++;
            end
            tick();
            tick();
            check("rnd_idle_valid", int'(req_valid), 0);
            check("rnd_idle_pending", int'(pending), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
